// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Op codes follow the funct3 encoding, so the op port can be cast straight to op_e.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITERATIONS = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        CALC  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_e;

    // funct3[2] separates the divide family from the multiply family
    function automatic logic op_is_div(input op_e o);
        return o[2];
    endfunction

    function automatic logic op_is_rem(input op_e o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

    function automatic logic a_is_signed(input op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic b_is_signed(input op_e o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned multiply (shift-add, right shift) or
// restoring divide (shift-subtract, left shift) over a 2*W accumulator.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   operand_i,
    output logic [2*W-1:0] acc_o
);
    import muldiv_pkg::*;

    logic [W:0]     mul_addend;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_acc;
    logic [W:0]     div_shifted;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_acc;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, the high
        // half accumulates; the carry out of the add shifts into bit 2W-1.
        mul_addend = acc_i[0] ? {1'b0, operand_i} : {(W+1){1'b0}};
        mul_sum    = {1'b0, acc_i[2*W-1:W]} + mul_addend;
        mul_acc    = {mul_sum, acc_i[W-1:1]};

        // Divide: high half is the partial remainder, low half the dividend
        // bits turning into quotient bits. W+1 bits keep the shifted remainder.
        div_shifted = acc_i[2*W-1:W-1];
        div_diff    = div_shifted - {1'b0, operand_i};
        if (div_diff[W]) begin
            div_acc = {div_shifted[W-1:0], acc_i[W-2:0], 1'b0};
        end else begin
            div_acc = {div_diff[W-1:0], acc_i[W-2:0], 1'b1};
        end

        acc_o = is_div ? div_acc : mul_acc;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: latches a request, runs a
// magnitude shift-add / shift-subtract loop, then applies the result sign.
module muldiv_sequencer #(
    parameter int data_width = muldiv_pkg::XLEN,
    parameter int ITERATIONS = muldiv_pkg::ITERATIONS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [data_width-1:0] operand_A,
    input  logic [data_width-1:0] operand_B,
    input  logic                  flush,
    output logic [data_width-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  hold_pipeline
);
    import muldiv_pkg::*;

    localparam int W     = data_width;
    localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [W-1:0]     SIGNED_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ITERATIONS - 1);

    state_e           state_q,  state_d;
    op_e              op_q,     op_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     opnd_q,   opnd_d;
    logic [2*W-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             neg_q,    neg_d;
    logic [W-1:0]     result_q, result_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;
    logic             hold_q,   hold_d;

    logic             sign_a;
    logic             sign_b;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic             div_by_zero;
    logic             div_ovf;
    logic             calc_is_div;
    logic [2*W-1:0]   step_acc;
    logic             prod_lo_zero;
    logic [W-1:0]     prod_hi_fix;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;

    assign calc_is_div = op_is_div(op_q);

    muldiv_step #(
        .W (W)
    ) u_step (
        .is_div    (calc_is_div),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    // Operand conditioning and sign fix-up, all from registered state
    always_comb begin
        sign_a      = a_is_signed(op_q) & a_q[W-1];
        sign_b      = b_is_signed(op_q) & b_q[W-1];
        mag_a       = sign_a ? -a_q : a_q;
        mag_b       = sign_b ? -b_q : b_q;
        div_by_zero = op_is_div(op_q) && (b_q == '0);
        div_ovf     = ((op_q == OP_DIV) || (op_q == OP_REM))
                      && (a_q == SIGNED_MIN) && (b_q == '1);

        // High half of the negated product: a borrow reaches it only when
        // the low half is all zeros.
        prod_lo_zero = (acc_q[W-1:0] == '0);
        prod_hi_fix  = neg_q ? (~acc_q[2*W-1:W] + {{(W-1){1'b0}}, prod_lo_zero})
                             : acc_q[2*W-1:W];
        quot_fix     = neg_q ? -acc_q[W-1:0]   : acc_q[W-1:0];
        rem_fix      = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op_e'(op);
                    a_d     = operand_A;
                    b_d     = operand_B;
                    state_d = PREP;
                end
            end
            PREP: begin
                cnt_d = CNT_LOAD;
                if (div_by_zero) begin
                    result_d = op_is_rem(op_q) ? a_q : '1;
                    state_d  = DONE;
                end else if (div_ovf) begin
                    result_d = op_is_rem(op_q) ? '0 : SIGNED_MIN;
                    state_d  = DONE;
                end else begin
                    // Remainder takes the dividend's sign, everything else the XOR
                    neg_d = op_is_rem(op_q) ? sign_a : (sign_a ^ sign_b);
                    if (op_is_div(op_q)) begin
                        acc_d  = {{W{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{W{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIXUP: begin
                unique case (op_q)
                    OP_MUL:                       result_d = acc_q[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_hi_fix;
                    OP_DIV, OP_DIVU:              result_d = quot_fix;
                    default:                      result_d = rem_fix;
                endcase
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort discards any result that would have been posted this edge
        if (flush && (state_q != IDLE)) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_comb begin
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
        hold_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIXUP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            hold_q   <= hold_d;
        end
    end

    // The IDLE+start term must stall in the request cycle itself, so it
    // cannot wait for a register.
    assign hold_pipeline = hold_q
                           | ((state_q == IDLE) & start & ~flush & ~rst);
    assign result        = result_q;
    assign done          = done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed results, latency,
// start-while-busy, flush and mid-operation reset.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] operand_A;
    logic [W-1:0] operand_B;
    logic         flush;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         hold_pipeline;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .data_width (W),
        .ITERATIONS (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .op            (op),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .flush         (flush),
        .result        (result),
        .done          (done),
        .busy          (busy),
        .hold_pipeline (hold_pipeline)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE and clock it in; afterwards one edge has elapsed
    task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op        = o;
        operand_A = x;
        operand_B = y;
        start     = 1'b1;
        #1;
        chk({tag, "_hold_req"}, {31'd0, hold_pipeline}, 32'd1);
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] expv, input int exp_lat);
        int lat;
        issue(tag, o, x, y);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        $display("op=%0d a=0x%h b=0x%h result=0x%h latency=%0d (%s)", o, x, y, result, lat, tag);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_result"}, result, expv);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold_done"}, {31'd0, hold_pipeline}, 32'd0);
        tick();
        chk({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_held"}, result, expv);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int seen;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL;
        operand_A = '0; operand_B = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_hold",   {31'd0, hold_pipeline}, 32'd0);
        tick();

        run_op("mul",      OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
        run_op("mulhu",    OP_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 35);
        run_op("mulh",     OP_MULH,   32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
        run_op("mulhsu",   OP_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 35);
        run_op("div_neg",  OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 35);
        run_op("rem_neg",  OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 35);
        run_op("remu",     OP_REMU,   32'd100,       32'd7,         32'd2,         35);
        run_op("divu_z",   OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2);
        run_op("remu_z",   OP_REMU,   32'h0000_1234, 32'd0,         32'h0000_1234, 2);
        run_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Second start while CALC is in flight must be dropped
        issue("busy_start", OP_DIVU, 32'd100, 32'd7);
        edges = 1;
        while (done !== 1'b1 && edges < 100) begin
            if (edges == 10) begin
                start = 1'b1; op = OP_MUL; operand_A = 32'd9; operand_B = 32'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            edges++;
        end
        start = 1'b0;
        $display("op=%0d a=0x%h b=0x%h result=0x%h latency=%0d (busy_start)", OP_DIVU, 32'd100, 32'd7, result, edges);
        chk("busy_start_latency", edges, 35);
        chk("busy_start_result", result, 32'd14);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("busy_start_dropped", seen, 0);

        // Flush in CALC: IDLE next cycle, no done, result unchanged
        issue("flush", OP_MUL, 32'h11, 32'h22);
        edges = 1;
        while (edges < 20) begin
            tick();
            edges++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("op=%0d a=0x%h b=0x%h flushed busy=%0d result=0x%h", OP_MUL, 32'h11, 32'h22, busy, result);
        chk("flush_busy",   {31'd0, busy}, 32'd0);
        chk("flush_done",   {31'd0, done}, 32'd0);
        chk("flush_hold",   {31'd0, hold_pipeline}, 32'd0);
        chk("flush_result", result, 32'd14);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("flush_no_done", seen, 0);
        run_op("mul_after_flush", OP_MUL, 32'd3, 32'd5, 32'd15, 35);

        // Flush beats start in IDLE
        op = OP_MUL; operand_A = 32'd1; operand_B = 32'd1;
        start = 1'b1; flush = 1'b1;
        #1;
        chk("idle_flush_hold", {31'd0, hold_pipeline}, 32'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        $display("op=%0d start+flush in IDLE busy=%0d", OP_MUL, busy);
        chk("idle_flush_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of CALC
        issue("mid_rst", OP_MUL, 32'd6, 32'd7);
        edges = 1;
        while (edges < 15) begin
            tick();
            edges++;
        end
        rst = 1'b1;
        tick();
        $display("op=%0d reset mid-operation result=0x%h busy=%0d", OP_MUL, result, busy);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_done",   {31'd0, done}, 32'd0);
        chk("mid_rst_hold",   {31'd0, hold_pipeline}, 32'd0);
        chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        run_op("mul_after_rst", OP_MUL, 32'd6, 32'd7, 32'd42, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter data_width, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter ITERATIONS, default 32, giving the number of iteration cycles.
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide: a request to begin an operation, sampled only in IDLE.
REQ-006 Port op SHALL be an input, 3 bits wide, carrying the RV32M funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Ports operand_A and operand_B SHALL be inputs, data_width bits wide, carrying rs1 and rs2; they are sampled on the start edge only.
REQ-008 Port flush SHALL be an input, 1 bit wide, that aborts the operation in flight.
REQ-009 Port result SHALL be an output, data_width bits wide, and be registered.
REQ-010 Port done SHALL be an output, 1 bit wide: a one-cycle pulse qualifying result.
REQ-011 Port busy SHALL be an output, 1 bit wide, high when the state is not IDLE.
REQ-012 Port hold_pipeline SHALL be an output, 1 bit wide, that stalls the pipeline while a result is pending.

Function
REQ-013 The FSM SHALL have the states IDLE, PREP, CALC, FIXUP and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch op and the operands, then go to PREP.
REQ-015 PREP SHALL form the operand magnitudes and the result sign, detect special cases, and load the iteration counter with ITERATIONS-1.
REQ-016 Sign rules:
- MULH, DIV and REM SHALL treat both operands as signed.
- MULHSU SHALL treat operand_A as signed and operand_B as unsigned.
- MULHU, DIVU and REMU SHALL treat both operands as unsigned.
- MUL SHALL use its low word, which is sign-independent.
REQ-017 CALC SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, over a 2*data_width product/remainder register. It SHALL exit to FIXUP when the counter reaches 0.
REQ-018 FIXUP SHALL apply two's-complement negation to the magnitude result when the result sign is set.
- Quotient sign = signA XOR signB.
- Remainder sign = sign of the dividend.
REQ-019 Result selection:
- MUL SHALL return product[31:0].
- MULH, MULHSU and MULHU SHALL return product[63:32].
- DIV and DIVU SHALL return the quotient.
- REM and REMU SHALL return the remainder.
REQ-020 With start accepted at edge N, the normal path SHALL be PREP at N+1, CALC at N+2..N+33, FIXUP at N+34 and DONE at N+35. done=1 and result are valid during the DONE cycle.
REQ-021 A divisor of 0 SHALL make PREP go directly to DONE, with DIV/DIVU returning all ones and REM/REMU returning the dividend.
REQ-022 Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF) SHALL make PREP go directly to DONE, with DIV returning 0x80000000 and REM returning 0.
REQ-023 DONE SHALL return to IDLE unconditionally on the next edge, and done SHALL deassert there.
REQ-024 result SHALL hold its value after DONE until the next operation's DONE.
REQ-025 hold_pipeline SHALL be (IDLE and start) OR (state in PREP, CALC or FIXUP), and SHALL be low in the DONE cycle.
REQ-026 start SHALL be ignored when the state is not IDLE, and the latched operands SHALL remain unchanged.
REQ-027 flush=1 in any state other than IDLE SHALL force IDLE on the next edge, with no done pulse and result unchanged.
REQ-028 flush SHALL have priority over start in IDLE, so no operation is accepted in that cycle.
REQ-029 The arithmetic SHALL wrap modulo 2^data_width, and the FSM SHALL raise no overflow or exception flags.

Reset
REQ-030 rst=1 at a clock edge SHALL force:
- state to IDLE;
- result to 0;
- done, busy and hold_pipeline to 0;
- the counter and internal registers to 0.
REQ-031 rst SHALL take priority over flush and start, including when it is asserted mid-CALC.

Structure
REQ-032 A shared package muldiv_pkg SHALL hold the op enum (funct3 encoding), the state enum, and the constants XLEN=32 and ITERATIONS=32.
REQ-033 One combinational sub-module, muldiv_step, SHALL implement a single multiply/divide iteration.
REQ-034 The FSM, counter and sign fix-up SHALL remain in muldiv_sequencer.

Verification
REQ-035 Multiply: MUL with A=0x00000007 and B=0xFFFFFFFD SHALL give done at N+35 and result 0xFFFFFFEB. MULHU with the same operands SHALL give 0x00000006.
REQ-036 Signed divide: DIV with A=-7 and B=2 SHALL give 0xFFFFFFFD, and REM with the same operands SHALL give 0xFFFFFFFF, each at N+35.
REQ-037 Special cases:
- DIVU with A=0x1234 and B=0 SHALL give done at N+2 and result 0xFFFFFFFF.
- REM with A=0x80000000 and B=0xFFFFFFFF SHALL give done at N+2 and result 0.
REQ-038 Start while busy: a start pulse with new operands at N+10 SHALL leave the in-flight result unchanged, and the second request SHALL be dropped.
REQ-039 Flush: flush=1 at N+20 SHALL give IDLE at N+21 with no done pulse and busy=0. A following MUL 3x5 SHALL then return 15.
REQ-040 Mid-operation reset: rst at N+15 SHALL give result=0, done=0 and hold_pipeline=0 on the next cycle, and the FSM SHALL accept start after rst deasserts.
